// File: rtl/entrega_pkg.sv
// Shared encodings for the delivery-round sequencer: 3-bit state codes (also the estado_dbg values).
package entrega_pkg;

    localparam logic [2:0] EST_OCIOSO   = 3'd0;
    localparam logic [2:0] EST_PREPARA  = 3'd1;
    localparam logic [2:0] EST_CONTANDO = 3'd2;
    localparam logic [2:0] EST_ALERTA   = 3'd3;
    localparam logic [2:0] EST_PAUSADO  = 3'd4;
    localparam logic [2:0] EST_EXPIROU  = 3'd5;
    localparam logic [2:0] EST_VITORIA  = 3'd6;

    function automatic logic em_contagem(input logic [2:0] estado);
        return (estado == EST_CONTANDO) || (estado == EST_ALERTA);
    endfunction

endpackage

// File: rtl/contador_max.sv
// Per-delivery timeout counter 0..M-1 with async and sync clears; fim at M-1, meio at M/2-1.
module contador_max #(
    parameter int M = 8,
    parameter int N = 4
) (
    input  logic         clock,
    input  logic         zera_as,
    input  logic         zera_s,
    input  logic         conta,
    output logic [N-1:0] Q,
    output logic         fim,
    output logic         meio
);

    always_ff @(posedge clock or posedge zera_as) begin
        if (zera_as) begin
            Q <= '0;
        end else if (zera_s) begin
            Q <= '0;
        end else if (conta) begin
            Q <= (Q == N'(M - 1)) ? '0 : Q + N'(1);
        end
    end

    assign fim  = (Q == N'(M - 1));
    assign meio = (Q == N'(M / 2 - 1));

endmodule

// File: rtl/gerador_tick.sv
// Prescaler for the timeout timer: counts 0..TICK_DIV-1 while enabled, tick on the last count.
module gerador_tick #(
    parameter int TICK_DIV = 50000000
) (
    input  logic clock,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0] ULTIMO = W'(TICK_DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clock) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == ULTIMO) ? '0 : cnt + W'(1);
        end
    end

    assign tick = en && (cnt == ULTIMO);

endmodule

// File: rtl/entrega_timer_ctrl.sv
// Delivery-round sequencer: drives contador_max as a timeout timer, counts deliveries.
// Optional pause support is compiled in with `define ENTREGA_PAUSE_EN.
module entrega_timer_ctrl
    import entrega_pkg::*;
#(
    parameter int TICK_DIV = 50000000,
    parameter int N_ENT    = 8,
    parameter int W_ENT    = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             iniciar,
    input  logic             entregou,
    input  logic             pausa,
    input  logic             fim_timer,
    input  logic             meio_timer,
    output logic             conta_timer,
    output logic             zera_timer,
    output logic [W_ENT-1:0] entregas,
    output logic             jogando,
    output logic             alerta,
    output logic             expirou,
    output logic             vitoria,
    output logic [2:0]       estado_dbg
);

    localparam logic [W_ENT-1:0] N_LIM  = W_ENT'(N_ENT);
    localparam logic [W_ENT-1:0] N_ULT  = W_ENT'(N_ENT - 1);

    logic [2:0] estado, estado_prox;
    logic       zera_prox, inc_ent, clr_ent;
    logic       contando, tick, fim_ok, meio_ok;

    assign contando = em_contagem(estado);

    // While the clear pulse is out the timer still shows its old value, so fim/meio are stale.
    assign fim_ok  = fim_timer  && !zera_timer;
    assign meio_ok = meio_timer && !zera_timer;

`ifdef ENTREGA_PAUSE_EN
    logic salvo_alerta;
`else
    logic unused_pausa;
    assign unused_pausa = pausa;
`endif

    always_comb begin
        estado_prox = estado;
        zera_prox   = 1'b0;
        inc_ent     = 1'b0;
        clr_ent     = 1'b0;
        case (estado)
            EST_OCIOSO, EST_EXPIROU, EST_VITORIA: begin
                if (iniciar) begin
                    estado_prox = EST_PREPARA;
                    zera_prox   = 1'b1;
                    clr_ent     = 1'b1;
                end
            end
            EST_PREPARA: estado_prox = EST_CONTANDO;
            EST_CONTANDO, EST_ALERTA: begin
                if (entregou) begin
                    zera_prox   = 1'b1;
                    inc_ent     = 1'b1;
                    estado_prox = (entregas >= N_ULT) ? EST_VITORIA : EST_CONTANDO;
                end else if (fim_ok) begin
                    estado_prox = EST_EXPIROU;
`ifdef ENTREGA_PAUSE_EN
                end else if (pausa) begin
                    estado_prox = EST_PAUSADO;
`endif
                end else if (meio_ok && (estado == EST_CONTANDO)) begin
                    estado_prox = EST_ALERTA;
                end
            end
`ifdef ENTREGA_PAUSE_EN
            EST_PAUSADO: begin
                if (!pausa) begin
                    estado_prox = salvo_alerta ? EST_ALERTA : EST_CONTANDO;
                end
            end
`endif
            default: estado_prox = EST_OCIOSO;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado     <= EST_OCIOSO;
            zera_timer <= 1'b0;
            entregas   <= '0;
        end else begin
            estado     <= estado_prox;
            zera_timer <= zera_prox;
            if (clr_ent) begin
                entregas <= '0;
            end else if (inc_ent && (entregas != N_LIM)) begin
                entregas <= entregas + W_ENT'(1);
            end
        end
    end

`ifdef ENTREGA_PAUSE_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            salvo_alerta <= 1'b0;
        end else if (contando && (estado_prox == EST_PAUSADO)) begin
            salvo_alerta <= (estado == EST_ALERTA);
        end
    end
`endif

    // Prescaler restarts on every timer clear so each delivery gets a full first tick period.
    gerador_tick #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clock(clock),
        .reset(reset),
        .en   (contando),
        .clr  (zera_prox),
        .tick (tick)
    );

    assign conta_timer = tick && !zera_timer;
    assign jogando     = contando || (estado == EST_PAUSADO);
`ifdef ENTREGA_PAUSE_EN
    assign alerta      = (estado == EST_ALERTA) || ((estado == EST_PAUSADO) && salvo_alerta);
`else
    assign alerta      = (estado == EST_ALERTA);
`endif
    assign expirou     = (estado == EST_EXPIROU);
    assign vitoria     = (estado == EST_VITORIA);
    assign estado_dbg  = estado;

endmodule

// File: tb/tb_entrega_timer_ctrl.sv
// Bench for entrega_timer_ctrl driving a contador_max (M=8), checked cycle by cycle against a round model.
module tb_entrega_timer_ctrl;
    import entrega_pkg::*;

    localparam int TD = 4;
    localparam int NE = 3;
    localparam int WE = 4;
    localparam int M  = 8;
`ifdef ENTREGA_PAUSE_EN
    localparam bit PAUSE_EN = 1'b1;
`else
    localparam bit PAUSE_EN = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset, iniciar, entregou, pausa;
    logic          fim_timer, meio_timer, conta_timer, zera_timer;
    logic [WE-1:0] entregas;
    logic          jogando, alerta, expirou, vitoria;
    logic [2:0]    estado_dbg;
    logic [3:0]    q;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    entrega_timer_ctrl #(.TICK_DIV(TD), .N_ENT(NE), .W_ENT(WE)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .entregou(entregou), .pausa(pausa),
        .fim_timer(fim_timer), .meio_timer(meio_timer), .conta_timer(conta_timer),
        .zera_timer(zera_timer), .entregas(entregas), .jogando(jogando), .alerta(alerta),
        .expirou(expirou), .vitoria(vitoria), .estado_dbg(estado_dbg)
    );

    contador_max #(.M(M), .N(4)) u_timer (
        .clock(clock), .zera_as(reset), .zera_s(zera_timer), .conta(conta_timer),
        .Q(q), .fim(fim_timer), .meio(meio_timer)
    );

    // Round model: phase, deliveries, active cycles modulo TD, timer value, pending clear.
    logic [2:0] m_mode;
    int         m_ent, m_pre, m_q;
    bit         m_zera, m_saved;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = EST_OCIOSO; m_ent = 0; m_pre = 0; m_q = 0; m_zera = 0; m_saved = 0;
    endtask

    function automatic bit m_run();
        return (m_mode == EST_CONTANDO) || (m_mode == EST_ALERTA);
    endfunction

    function automatic bit m_conta();
        return m_run() && (m_pre == TD - 1) && !m_zera;
    endfunction

    task automatic model_step(input bit r, input bit i, input bit e, input bit p);
        logic [2:0] nmode;
        int         npre, nq, nent;
        bit         nzera, nsaved, fim, meio;
        if (r) begin
            model_reset();
            return;
        end
        fim    = !m_zera && (m_q == M - 1);
        meio   = !m_zera && (m_q == M / 2 - 1);
        nq     = m_zera ? 0 : (m_conta() ? (m_q + 1) % M : m_q);
        npre   = m_run() ? (m_pre + 1) % TD : m_pre;
        nmode  = m_mode; nent = m_ent; nzera = 0; nsaved = m_saved;
        case (m_mode)
            EST_OCIOSO, EST_EXPIROU, EST_VITORIA:
                if (i) begin nmode = EST_PREPARA; nent = 0; npre = 0; nzera = 1; end
            EST_PREPARA: nmode = EST_CONTANDO;
            EST_CONTANDO, EST_ALERTA: begin
                if (e) begin
                    nent  = (m_ent + 1 > NE) ? NE : m_ent + 1;
                    nmode = (m_ent + 1 >= NE) ? EST_VITORIA : EST_CONTANDO;
                    nzera = 1; npre = 0;
                end else if (fim) begin
                    nmode = EST_EXPIROU;
                end else if (p && PAUSE_EN) begin
                    nsaved = (m_mode == EST_ALERTA);
                    nmode  = EST_PAUSADO;
                end else if (meio) begin
                    nmode = EST_ALERTA;
                end
            end
            EST_PAUSADO: if (!p) nmode = m_saved ? EST_ALERTA : EST_CONTANDO;
            default: nmode = EST_OCIOSO;
        endcase
        m_mode = nmode; m_ent = nent; m_pre = npre; m_q = nq; m_zera = nzera; m_saved = nsaved;
    endtask

    // One clock: compare visible outputs with the model, then drive inputs for the next edge.
    task automatic step(input bit r, input bit i, input bit e, input bit p);
        logic [8:0] exp_ctrl;
        @(negedge clock);
        exp_ctrl = {m_conta(), m_zera, m_run() || (m_mode == EST_PAUSADO),
                    (m_mode == EST_ALERTA) || ((m_mode == EST_PAUSADO) && m_saved),
                    m_mode == EST_EXPIROU, m_mode == EST_VITORIA, m_mode};
        check("ctrl", 32'({conta_timer, zera_timer, jogando, alerta, expirou, vitoria, estado_dbg}),
              32'(exp_ctrl));
        check("entregas", 32'(entregas), 32'(m_ent));
        check("timer_q", 32'(q), 32'(m_q));
        reset = r; iniciar = i; entregou = e; pausa = p;
        model_step(r, i, e, p);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog no finish by t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit p_lvl;
        bool_loop: begin end
        reset = 1; iniciar = 0; entregou = 1; pausa = 1;
        model_reset();
        repeat (2) @(posedge clock);
        step(1, 0, 1, 1);
        for (int k = 0; k < 3; k++) step(0, 0, 1, 1);
        check("rst_estado", 32'(estado_dbg), 32'(EST_OCIOSO));
        check("rst_outs", 32'({conta_timer, zera_timer, jogando, alerta, expirou, vitoria}), 32'(0));

        // Timeout: seven ticks with no delivery
        step(0, 1, 0, 0);
        idle(40);
        check("timeout_expirou", 32'(expirou), 32'(1));
        check("timeout_q", 32'(q), 32'(M - 1));

        // Restart from EXPIROU; iniciar while counting has no effect
        step(0, 1, 0, 0);
        idle(4);
        step(0, 1, 0, 0);
        idle(3);
        check("restart_estado", 32'(estado_dbg), 32'(EST_CONTANDO));
        check("restart_entregas", 32'(entregas), 32'(0));

        // Victory: three deliveries ten clocks apart
        step(0, 1, 0, 0);
        for (int k = 0; k < NE; k++) begin
            idle(9);
            step(0, 0, 1, 0);
        end
        idle(2);
        check("victory_vitoria", 32'(vitoria), 32'(1));
        check("victory_entregas", 32'(entregas), 32'(NE));

        // Delivery on the first cycle fim_timer is high beats the timeout
        step(0, 1, 0, 0);
        begin
            int n = 0;
            while (!(m_run() && m_q == M - 1 && !m_zera) && n < 80) begin
                idle(1);
                n++;
            end
            check("sim_bound", 32'(n < 80), 32'(1));
        end
        step(0, 0, 1, 0);
        idle(2);
        check("sim_expirou", 32'(expirou), 32'(0));
        check("sim_entregas", 32'(entregas), 32'(1));
        check("sim_q", 32'(q), 32'(0));

`ifdef ENTREGA_PAUSE_EN
        // Pause in ALERTA: timer frozen, alerta held, resumes into ALERTA
        step(0, 1, 0, 0);
        begin
            int n = 0;
            int q_hold;
            while (m_mode != EST_ALERTA && n < 80) begin
                idle(1);
                n++;
            end
            check("pause_bound", 32'(n < 80), 32'(1));
            q_hold = m_q;
            for (int k = 0; k < 20; k++) step(0, 0, k[0], 1);
            check("pause_q", 32'(q), 32'(q_hold));
            check("pause_alerta", 32'(alerta), 32'(1));
            idle(8);
            check("pause_resume", 32'(estado_dbg), 32'(EST_ALERTA));
        end
`endif

        // Reset in the middle of a round
        step(0, 1, 0, 0);
        idle(8);
        step(1, 0, 0, 0);
        idle(1);
        check("midrst_estado", 32'(estado_dbg), 32'(EST_OCIOSO));
        check("midrst_zera", 32'(zera_timer), 32'(0));

        // Random traffic
        p_lvl = 0;
        for (int k = 0; k < 2500; k++) begin
            if ($urandom_range(0, 9) == 0) p_lvl = !p_lvl;
            step($urandom_range(0, 399) == 0, $urandom_range(0, 24) == 0,
                 $urandom_range(0, 13) == 0, p_lvl);
        end
        idle(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
